// File: rtl/dsp_slice_top.sv
// Single DSP slice: A/B/C/D input pipelines, optional D+/-A pre-adder, 25x18 signed multiplier,
// X/Y/Z operand muxes, 48-bit ALU with carry select, pattern detect and cascade outputs.
module dsp_slice_top #(
  parameter int          A_WIDTH   = 30,
  parameter int          B_WIDTH   = 18,
  parameter int          C_WIDTH   = 48,
  parameter int          D_WIDTH   = 25,
  parameter int          A_REG     = 1,
  parameter int          B_REG     = 1,
  parameter int          C_REG     = 1,
  parameter int          D_REG     = 1,
  parameter int          AD_REG    = 1,
  parameter int          M_REG     = 1,
  parameter int          P_REG     = 1,
  parameter string       USE_DPORT = "FALSE",
  parameter string       A_INPUT   = "DIRECT",
  parameter string       B_INPUT   = "DIRECT",
  parameter logic [47:0] PATTERN   = 48'h0000_0000_0000,
  parameter logic [47:0] MASK      = 48'h3FFF_FFFF_FFFF
) (
  input  logic               clk,
  input  logic               rsta, rstb, rstc, rstd, rstm, rstp,
  input  logic               rstctrl, rstalumode, rstinmode, rstallcarryin,
  input  logic [A_WIDTH-1:0] a, acin,
  input  logic [B_WIDTH-1:0] b, bcin,
  input  logic [C_WIDTH-1:0] c,
  input  logic [D_WIDTH-1:0] d,
  input  logic               cea1, cea2, ceb1, ceb2, cec, ced, cead, cem, cep,
  input  logic               ceinmode, cectrl, cealumode, cecarryin,
  input  logic [4:0]         inmode,
  input  logic [6:0]         opmode,
  input  logic [3:0]         alumode,
  input  logic [2:0]         carryinsel,
  input  logic               carryin, carrycascin, multsignin,
  input  logic [47:0]        pcin,
  output logic [A_WIDTH-1:0] acout,
  output logic [B_WIDTH-1:0] bcout,
  output logic [47:0]        pcout, p,
  output logic [3:0]         carryout,
  output logic               carrycascout, multsignout,
  output logic               patterndetect, patternbdetect, overflow, underflow
);
  localparam bit USE_D = (USE_DPORT == "TRUE");

  logic [A_WIDTH-1:0] a_in_s, a1_r, a2_r, a1_sel_s, a_fin_s;
  logic [B_WIDTH-1:0] b_in_s, b1_r, b2_r, b1_sel_s, b_fin_s, mult_b_s;
  logic [47:0]        c_r, c_fin_s;
  logic [24:0]        d_r, d_fin_s, ad_r, ad_s, ad_fin_s, a_pre_s, a_pa_s, d_pa_s, mult_a_s;
  logic [4:0]         inmode_r;
  logic [6:0]         opmode_r;
  logic [3:0]         alumode_r;
  logic [2:0]         carryinsel_r;
  logic               carryin_r;
  logic [42:0]        prod_s;
  logic [47:0]        m_s, m_r, m_fin_s;
  logic [47:0]        x_s, y_s, z_s, alu_s;
  logic [49:0]        sum_z_s, sum_nz_s;
  logic               cin_s, co_s, pd_s, pbd_s;
  logic [47:0]        p_r;
  logic               carry_r, pd_r, pbd_r, ovf_r, unf_r;

  assign a_in_s   = (A_INPUT == "CASCADE") ? acin : a;
  assign b_in_s   = (B_INPUT == "CASCADE") ? bcin : b;
  assign a1_sel_s = (A_REG == 2) ? a1_r : a_in_s;
  assign b1_sel_s = (B_REG == 2) ? b1_r : b_in_s;
  assign a_fin_s  = (A_REG == 0) ? a_in_s : a2_r;
  assign b_fin_s  = (B_REG == 0) ? b_in_s : b2_r;
  assign c_fin_s  = (C_REG == 0) ? 48'(c) : c_r;
  assign d_fin_s  = (D_REG == 0) ? 25'(d) : d_r;
  assign acout    = a_fin_s;
  assign bcout    = b_fin_s;

  // A pipeline: depth 2 chains A1 into A2, depth 1 loads A2 straight from the input
  always_ff @(posedge clk) begin
    if (!rsta) begin
      a1_r <= {A_WIDTH{1'b0}};
      a2_r <= {A_WIDTH{1'b0}};
    end else begin
      if (cea1) a1_r <= a_in_s;
      if (cea2) a2_r <= (A_REG == 2) ? a1_r : a_in_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      b1_r <= {B_WIDTH{1'b0}};
      b2_r <= {B_WIDTH{1'b0}};
    end else begin
      if (ceb1) b1_r <= b_in_s;
      if (ceb2) b2_r <= (B_REG == 2) ? b1_r : b_in_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstc) c_r <= 48'd0;
    else if (cec) c_r <= 48'(c);
  end

  // D and the pre-adder result share one reset group
  always_ff @(posedge clk) begin
    if (!rstd) begin
      d_r  <= 25'd0;
      ad_r <= 25'd0;
    end else begin
      if (ced)  d_r  <= 25'(d);
      if (cead) ad_r <= ad_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstinmode) inmode_r <= 5'd0;
    else if (ceinmode) inmode_r <= inmode;
  end

  always_ff @(posedge clk) begin
    if (!rstctrl) begin
      opmode_r     <= 7'd0;
      carryinsel_r <= 3'd0;
    end else if (cectrl) begin
      opmode_r     <= opmode;
      carryinsel_r <= carryinsel;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstalumode) alumode_r <= 4'd0;
    else if (cealumode) alumode_r <= alumode;
  end

  always_ff @(posedge clk) begin
    if (!rstallcarryin) carryin_r <= 1'b0;
    else if (cecarryin) carryin_r <= carryin;
  end

  // Pre-adder operand selection; inmode[0] still picks A1/A2 when the D port is unused
  always_comb begin
    a_pre_s = inmode_r[0] ? a1_sel_s[24:0] : a_fin_s[24:0];
    if (inmode_r[1]) a_pa_s = 25'd0;
    else             a_pa_s = a_pre_s;
    if (inmode_r[2]) d_pa_s = d_fin_s;
    else             d_pa_s = 25'd0;
    if (inmode_r[3]) ad_s = d_pa_s - a_pa_s;
    else             ad_s = d_pa_s + a_pa_s;
  end

  assign ad_fin_s = (AD_REG == 0) ? ad_s : ad_r;
  assign mult_a_s = USE_D ? ad_fin_s : a_pre_s;
  assign mult_b_s = inmode_r[4] ? b1_sel_s : b_fin_s;
  assign prod_s   = {{18{mult_a_s[24]}}, mult_a_s} * {{25{mult_b_s[17]}}, mult_b_s[17:0]};
  assign m_s      = {{5{prod_s[42]}}, prod_s};

  always_ff @(posedge clk) begin
    if (!rstm) m_r <= 48'd0;
    else if (cem) m_r <= m_s;
  end

  assign m_fin_s     = (M_REG == 0) ? m_s : m_r;
  assign multsignout = m_fin_s[47];

  // Operand muxes and carry-in source
  always_comb begin
    case (opmode_r[1:0])
      2'b00:   x_s = 48'd0;
      2'b01:   x_s = m_fin_s;
      2'b10:   x_s = p;
      2'b11:   x_s = 48'({a_fin_s, b_fin_s});
      default: x_s = 48'd0;
    endcase
    case (opmode_r[3:2])
      2'b10:   y_s = {48{1'b1}};
      2'b11:   y_s = c_fin_s;
      default: y_s = 48'd0;
    endcase
    case (opmode_r[6:4])
      3'b001:  z_s = pcin;
      3'b010:  z_s = p;
      3'b011:  z_s = c_fin_s;
      3'b100:  z_s = p;
      3'b101:  z_s = {{17{pcin[47]}}, pcin[47:17]};
      3'b110:  z_s = {{17{p[47]}}, p[47:17]};
      default: z_s = 48'd0;
    endcase
    case (carryinsel_r)
      3'b000:  cin_s = carryin_r;
      3'b001:  cin_s = ~pcin[47];
      3'b010:  cin_s = carrycascin;
      3'b011:  cin_s = pcin[47];
      3'b100:  cin_s = carry_r;
      3'b101:  cin_s = ~p[47];
      3'b110:  cin_s = ~(a_fin_s[24] ^ b_fin_s[17]);
      3'b111:  cin_s = p[47];
      default: cin_s = 1'b0;
    endcase
  end

  assign sum_z_s  = {2'b00, z_s} + {2'b00, x_s} + {2'b00, y_s} + {49'd0, cin_s};
  assign sum_nz_s = {2'b00, ~z_s} + {2'b00, x_s} + {2'b00, y_s} + {49'd0, cin_s};

  // Subtract is ~(~Z + X + Y + CIN) so both arithmetic flavours share one adder shape
  always_comb begin
    co_s = 1'b0;
    case (alumode_r)
      4'b0000: begin alu_s = sum_z_s[47:0];   co_s = sum_z_s[48];  end
      4'b0001: begin alu_s = sum_nz_s[47:0];  co_s = sum_nz_s[48]; end
      4'b0010: begin alu_s = ~sum_z_s[47:0];  co_s = sum_z_s[48];  end
      4'b0011: begin alu_s = ~sum_nz_s[47:0]; co_s = sum_nz_s[48]; end
      4'b0100, 4'b0111: alu_s = x_s ^ z_s;
      4'b0101, 4'b0110: alu_s = ~(x_s ^ z_s);
      4'b1000: alu_s = x_s | z_s;
      4'b1001: alu_s = ~(x_s | z_s);
      4'b1010: alu_s = x_s | ~z_s;
      4'b1011: alu_s = ~x_s & z_s;
      4'b1100: alu_s = x_s & z_s;
      4'b1101: alu_s = x_s & ~z_s;
      4'b1110: alu_s = ~(x_s & z_s);
      4'b1111: alu_s = ~x_s | z_s;
      default: alu_s = 48'd0;
    endcase
  end

  assign pd_s  = (((alu_s ^ PATTERN) & ~MASK) == 48'd0);
  assign pbd_s = (((alu_s ^ ~PATTERN) & ~MASK) == 48'd0);

  // P stage: result, carry and pattern flags move together
  always_ff @(posedge clk) begin
    if (!rstp) begin
      p_r     <= 48'd0;
      carry_r <= 1'b0;
      pd_r    <= 1'b0;
      pbd_r   <= 1'b0;
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
    end else if (cep) begin
      p_r     <= alu_s;
      carry_r <= co_s;
      pd_r    <= pd_s;
      pbd_r   <= pbd_s;
      ovf_r   <= pd_r & ~pd_s & ~pbd_s;
      unf_r   <= pbd_r & ~pd_s & ~pbd_s;
    end
  end

  assign p              = (P_REG == 0) ? alu_s : p_r;
  assign pcout          = p;
  assign carryout       = {((P_REG == 0) ? co_s : carry_r), 3'b000};
  assign carrycascout   = carryout[3];
  assign patterndetect  = (P_REG == 0) ? pd_s : pd_r;
  assign patternbdetect = (P_REG == 0) ? pbd_s : pbd_r;
  assign overflow       = (P_REG == 0) ? (pd_r & ~pd_s & ~pbd_s) : ovf_r;
  assign underflow      = (P_REG == 0) ? (pbd_r & ~pd_s & ~pbd_s) : unf_r;

  logic unused_s;
  assign unused_s = multsignin;
endmodule

// File: tb/tb_dsp_slice_top.sv
// Directed bench for dsp_slice_top at default parameters: reset, MAC paths, subtract,
// carry-in, pattern/overflow flags and P clock-enable hold.
module tb_dsp_slice_top;
  logic        clk = 1'b0;
  logic        rsta, rstb, rstc, rstd, rstm, rstp, rstctrl, rstalumode, rstinmode, rstallcarryin;
  logic [29:0] a, acin, acout;
  logic [17:0] b, bcin, bcout;
  logic [47:0] c, pcin, pcout, p;
  logic [24:0] d;
  logic        cea1, cea2, ceb1, ceb2, cec, ced, cead, cem, cep, ceinmode, cectrl, cealumode, cecarryin;
  logic [4:0]  inmode;
  logic [6:0]  opmode;
  logic [3:0]  alumode, carryout;
  logic [2:0]  carryinsel;
  logic        carryin, carrycascin, multsignin;
  logic        carrycascout, multsignout, patterndetect, patternbdetect, overflow, underflow;

  int total = 0;
  int bad   = 0;

  dsp_slice_top dut (
    .clk(clk), .rsta(rsta), .rstb(rstb), .rstc(rstc), .rstd(rstd), .rstm(rstm), .rstp(rstp),
    .rstctrl(rstctrl), .rstalumode(rstalumode), .rstinmode(rstinmode), .rstallcarryin(rstallcarryin),
    .a(a), .acin(acin), .b(b), .bcin(bcin), .c(c), .d(d),
    .cea1(cea1), .cea2(cea2), .ceb1(ceb1), .ceb2(ceb2), .cec(cec), .ced(ced), .cead(cead),
    .cem(cem), .cep(cep), .ceinmode(ceinmode), .cectrl(cectrl), .cealumode(cealumode),
    .cecarryin(cecarryin), .inmode(inmode), .opmode(opmode), .alumode(alumode),
    .carryinsel(carryinsel), .carryin(carryin), .carrycascin(carrycascin), .multsignin(multsignin),
    .pcin(pcin), .acout(acout), .bcout(bcout), .pcout(pcout), .p(p), .carryout(carryout),
    .carrycascout(carrycascout), .multsignout(multsignout), .patterndetect(patterndetect),
    .patternbdetect(patternbdetect), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_rst(input logic v);
    {rsta, rstb, rstc, rstd, rstm, rstp, rstctrl, rstalumode, rstinmode, rstallcarryin} = {10{v}};
  endtask

  initial begin
    set_rst(1'b0);
    {cea1, cea2, ceb1, ceb2, cec, ced, cead, cem, cep, ceinmode, cectrl, cealumode, cecarryin} = {13{1'b1}};
    a = 30'd5; acin = 30'd9; b = 18'd7; bcin = 18'd3; c = 48'd12; d = 25'd3;
    pcin = 48'h8000_0000_0001; inmode = 5'b00000; opmode = 7'b0110011; alumode = 4'b0000;
    carryinsel = 3'b000; carryin = 1'b1; carrycascin = 1'b1; multsignin = 1'b0;
    tick(2);
    check("rst_p", p, 48'd0);
    check("rst_pcout", pcout, 48'd0);
    check("rst_carryout", 48'(carryout), 48'd0);
    check("rst_carrycascout", 48'(carrycascout), 48'd0);
    check("rst_pd", 48'(patterndetect), 48'd0);
    check("rst_pbd", 48'(patternbdetect), 48'd0);
    check("rst_ovf", 48'(overflow), 48'd0);
    check("rst_unf", 48'(underflow), 48'd0);

    // a*b through M, exact three-cycle latency
    set_rst(1'b1);
    a = 30'd5; b = 18'd7; c = 48'd0; opmode = 7'b0000101; alumode = 4'b0000; carryin = 1'b0;
    tick(3);
    check("mul_p", p, 48'd35);
    check("mul_msign", 48'(multsignout), 48'd0);
    check("acout", 48'(acout), 48'd5);
    check("bcout", 48'(bcout), 48'd7);

    a = 30'h3FFF_FFFB;
    tick(4);
    check("mul_neg_p", p, 48'hFFFF_FFFF_FFDD);
    check("mul_neg_msign", 48'(multsignout), 48'd1);

    a = 30'd5; c = 48'd12; opmode = 7'b0110011;
    tick(4);
    check("ab_plus_c", p, 48'h14_0013);
    check("ab_plus_c_pd", 48'(patterndetect), 48'd1);

    alumode = 4'b0011;
    tick(4);
    check("c_minus_ab", p, 48'hFFFF_FFEC_0005);
    check("c_minus_ab_pbd", 48'(patternbdetect), 48'd1);
    check("c_minus_ab_pd", 48'(patterndetect), 48'd0);

    opmode = 7'b0001100; alumode = 4'b0000; carryin = 1'b1; carryinsel = 3'b000;
    tick(4);
    check("c_plus_cin", p, 48'd13);
    check("c_plus_cin_co", 48'(carryout), 48'd0);

    // bits 47:46 leave 00 while the previous result matched the pattern
    opmode = 7'b0000011; a = 30'h1000_0000; b = 18'd0; carryin = 1'b0;
    tick(2);
    check("ovf_p", p, 48'h4000_0000_0000);
    check("ovf_set", 48'(overflow), 48'd1);
    check("ovf_unf", 48'(underflow), 48'd0);
    tick(1);
    check("ovf_clear", 48'(overflow), 48'd0);

    opmode = 7'b0000000;
    tick(4);
    check("zero_p", p, 48'd0);
    check("zero_pd", 48'(patterndetect), 48'd1);

    cep = 1'b0; opmode = 7'b0110011; a = 30'd5; b = 18'd7; c = 48'd12;
    tick(4);
    check("hold_p", p, 48'd0);
    check("hold_pcout", pcout, 48'd0);
    check("hold_pd", 48'(patterndetect), 48'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
